// File: rtl/mul_pkg.sv
// Shared multiply-unit definitions: op-select encodings, default widths, pipeline entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_pkg;

    // Op select as seen by the decoder and issue logic; drives in_signed directly.
    localparam logic MUL_OP_MULTU = 1'b0;
    localparam logic MUL_OP_MULT  = 1'b1;

    localparam int MUL_DATA_W_DEF = 32;
    localparam int MUL_STAGES_DEF = 6;
    localparam int MUL_TAG_W_DEF  = 6;

    // Pipeline entry at default widths; mul_pipe keeps the same field order at its own widths.
    typedef struct packed {
        logic                      valid;
        logic [MUL_DATA_W_DEF-1:0] hi;
        logic [MUL_DATA_W_DEF-1:0] lo;
        logic [MUL_TAG_W_DEF-1:0]  tag;
    } mul_entry_t;

endpackage

// File: rtl/mul_core.sv
// Combinational signed/unsigned multiply, full 2*DATA_W product; swappable for a DSP macro.
// Latency: 0 cycles (purely combinational).
// Backpressure: none, no state.
module mul_core
    import mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W_DEF
) (
    input  logic                  op,
    input  logic [DATA_W-1:0]     x,
    input  logic [DATA_W-1:0]     y,
    output logic [2*DATA_W-1:0]   prod
);

    logic                sx;
    logic                sy;
    logic [2*DATA_W-1:0] xe;
    logic [2*DATA_W-1:0] ye;

    assign sx = (op == MUL_OP_MULT) & x[DATA_W-1];
    assign sy = (op == MUL_OP_MULT) & y[DATA_W-1];

    // Extending straight to 2*DATA_W gives the same low 2*DATA_W bits as the
    // (DATA_W+1)-bit signed product, without carrying unused upper bits.
    assign xe = {{DATA_W{sx}}, x};
    assign ye = {{DATA_W{sy}}, y};

    assign prod = xe * ye;

endmodule

// File: rtl/mul_pipe.sv
// Elastic pipelined integer multiplier returning {hi, lo} and a pass-through tag in order.
// Latency: STAGES cycles from input transfer to out_valid; one op per cycle throughput.
// Backpressure: stages hold when blocked, bubbles collapse; in_ready drops only when all STAGES are full.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W_DEF,
    parameter int STAGES = MUL_STAGES_DEF,
    parameter int TAG_W  = MUL_TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic [TAG_W-1:0]  tag;
    } stage_t;

    logic [2*DATA_W-1:0] prod;
    stage_t              head;
    stage_t              stg [STAGES];
    stage_t              up  [STAGES];
    logic [STAGES-1:0]   v;
    logic [STAGES-1:0]   adv;

    mul_core #(.DATA_W(DATA_W)) u_core (
        .op   (in_signed),
        .x    (in_x),
        .y    (in_y),
        .prod (prod)
    );

    assign head = {in_valid, prod, in_tag};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign up[k] = head;
        end else begin : g_next
            assign up[k] = stg[k-1];
        end

        assign v[k] = stg[k].valid;
        // Unrolled adv chain: stage k moves if any stage at or beyond it is empty, or the tail drains.
        assign adv[k] = out_ready | ~(&v[STAGES-1:k]);

        // Payload loads only with a valid entry so the output holds while idle.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stg[k] <= '0;
            end else if (flush) begin
                stg[k].valid <= 1'b0;
            end else if (adv[k]) begin
                if (up[k].valid) begin
                    stg[k] <= up[k];
                end else begin
                    stg[k].valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign busy      = |v;
    assign out_valid = stg[STAGES-1].valid;
    assign out_hi    = stg[STAGES-1].hi;
    assign out_lo    = stg[STAGES-1].lo;
    assign out_tag   = stg[STAGES-1].tag;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: queue-based reference model checked every cycle, plus literal vectors
// and parameter sweeps at 16/2 and 64/9.
module tb_mul_pipe;

    localparam int DW = 32;
    localparam int ST = 6;
    localparam int TW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [DW-1:0] in_x, in_y, out_hi, out_lo;
    logic [TW-1:0] in_tag, out_tag;

    logic          a_valid, a_ready, a_signed, a_ovalid, a_busy;
    logic [15:0]   a_x, a_y, a_hi, a_lo;
    logic [5:0]    a_tag, a_otag;
    logic          b_valid, b_ready, b_signed, b_ovalid, b_busy;
    logic [63:0]   b_x, b_y, b_hi, b_lo;
    logic [5:0]    b_tag, b_otag;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mul_pipe #(.DATA_W(DW), .STAGES(ST), .TAG_W(TW)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi), .out_lo(out_lo),
        .out_tag(out_tag), .busy(busy)
    );

    mul_pipe #(.DATA_W(16), .STAGES(2), .TAG_W(6)) u_s16 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(a_valid), .in_ready(a_ready),
        .in_signed(a_signed), .in_x(a_x), .in_y(a_y), .in_tag(a_tag),
        .out_valid(a_ovalid), .out_ready(1'b1), .out_hi(a_hi), .out_lo(a_lo),
        .out_tag(a_otag), .busy(a_busy)
    );

    mul_pipe #(.DATA_W(64), .STAGES(9), .TAG_W(6)) u_s64 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_valid), .in_ready(b_ready),
        .in_signed(b_signed), .in_x(b_x), .in_y(b_y), .in_tag(b_tag),
        .out_valid(b_ovalid), .out_ready(1'b1), .out_hi(b_hi), .out_lo(b_lo),
        .out_tag(b_otag), .busy(b_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unsigned product, then subtract the two's-complement weight of each negative operand.
    function automatic logic [127:0] ref_mul(input logic s, input int w,
                                             input logic [63:0] x, input logic [63:0] y);
        logic [127:0] mw, m2w, xs, ys, p;
        mw  = (128'd1 << w) - 128'd1;
        m2w = (128'd1 << (2 * w)) - 128'd1;
        xs  = {64'd0, x} & mw;
        ys  = {64'd0, y} & mw;
        p   = xs * ys;
        if (s) begin
            if (x[w-1]) p = p - (ys << w);
            if (y[w-1]) p = p - (xs << w);
        end
        return p & m2w;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] r;
        case ($urandom_range(0, 5))
            0:       r = 64'd0;
            1:       r = '1;
            2:       r = 64'd1 << (w - 1);
            3:       r = (64'd1 << (w - 1)) - 64'd1;
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    // Main scoreboard: ops in flight in acceptance order.
    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    typedef struct {
        logic [127:0] p;
        logic [5:0]   tag;
        int           acc;
    } sw_t;

    exp_t          q[$];
    exp_t          e;
    logic [127:0]  mp;
    logic          expv, hold_prev;
    logic [DW-1:0] ph, pl;
    logic [TW-1:0] pt;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            hold_prev = 1'b0;
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_hi", out_hi, '0);
            chk("rst_out_lo", out_lo, '0);
            chk("rst_out_tag", out_tag, '0);
            chk("rst_in_ready", in_ready, 1'b1);
        end else begin
            if (hold_prev) begin
                chk("hold_hi", out_hi, ph);
                chk("hold_lo", out_lo, pl);
                chk("hold_tag", out_tag, pt);
            end
            chk("in_ready", in_ready, (q.size() < ST) || out_ready);
            chk("busy", busy, q.size() != 0);
            expv = (q.size() != 0) && (cyc - q[0].acc >= ST);
            chk("out_valid", out_valid, expv);
            if (out_valid && expv) begin
                chk("out_hi", out_hi, q[0].hi);
                chk("out_lo", out_lo, q[0].lo);
                chk("out_tag", out_tag, q[0].tag);
            end
            hold_prev = out_valid && !out_ready && !flush;
            ph = out_hi;
            pl = out_lo;
            pt = out_tag;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && expv) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    mp    = ref_mul(in_signed, DW, 64'(in_x), 64'(in_y));
                    e.hi  = mp[2*DW-1:DW];
                    e.lo  = mp[DW-1:0];
                    e.tag = in_tag;
                    e.acc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    sw_t qa[$];
    sw_t qb[$];
    sw_t sa, sb;
    logic av, bv;

    always @(negedge clk) begin
        if (!reset) begin
            qa.delete();
        end else begin
            av = (qa.size() != 0) && (cyc - qa[0].acc >= 2);
            chk("s16_out_valid", a_ovalid, av);
            if (a_ovalid && av) begin
                chk("s16_prod", {96'd0, a_hi, a_lo}, qa[0].p);
                chk("s16_tag", a_otag, qa[0].tag);
                void'(qa.pop_front());
            end
            if (a_valid && a_ready) begin
                sa.p   = ref_mul(a_signed, 16, 64'(a_x), 64'(a_y));
                sa.tag = a_tag;
                sa.acc = cyc;
                qa.push_back(sa);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            qb.delete();
        end else begin
            bv = (qb.size() != 0) && (cyc - qb[0].acc >= 9);
            chk("s64_out_valid", b_ovalid, bv);
            if (b_ovalid && bv) begin
                chk("s64_prod", {b_hi, b_lo}, qb[0].p);
                chk("s64_tag", b_otag, qb[0].tag);
                void'(qb.pop_front());
            end
            if (b_valid && b_ready) begin
                sb.p   = ref_mul(b_signed, 64, b_x, b_y);
                sb.tag = b_tag;
                sb.acc = cyc;
                qb.push_back(sb);
            end
        end
    end

    // Issues one op on an empty pipe and checks latency plus the literal result.
    task automatic run_one(input logic s, input logic [31:0] x, input logic [31:0] y,
                           input logic [5:0] tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input string nm);
        int lat;
        lat       = -1;
        in_valid  = 1'b1;
        in_signed = s;
        in_x      = x;
        in_y      = y;
        in_tag    = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_latency"}, lat, ST);
        chk({nm, "_hi"}, out_hi, ehi);
        chk({nm, "_lo"}, out_lo, elo);
        chk({nm, "_tag"}, out_tag, tag);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) break;
        end
        chk({nm, "_idle"}, busy, 1'b0);
        @(posedge clk); #1;
    endtask

    int          acc;
    logic        ot, it;
    logic [63:0] tmp;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;
        a_valid = 1'b0; a_signed = 1'b0; a_x = '0; a_y = '0; a_tag = '0;
        b_valid = 1'b0; b_signed = 1'b0; b_x = '0; b_y = '0; b_tag = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        chk("pin_s_m1xm1", ref_mul(1'b1, 32, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 128'h1);
        chk("pin_u_maxsq", ref_mul(1'b0, 32, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 128'hFFFF_FFFE_0000_0001);
        chk("pin_s_minsq", ref_mul(1'b1, 32, 64'h8000_0000, 64'h8000_0000), 128'h4000_0000_0000_0000);
        chk("pin_s16_mix", ref_mul(1'b1, 16, 64'h8000, 64'h7FFF), 128'hC000_8000);
        chk("pin_s64_m1x2", ref_mul(1'b1, 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2), ~128'h1);

        run_one(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 32'h0000_0000, 32'h0000_0001, "s_m1xm1");
        run_one(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFE, 32'h0000_0001, "u_maxsq");
        run_one(1'b1, 32'h8000_0000, 32'h8000_0000, 6'd3, 32'h4000_0000, 32'h0000_0000, "s_minsq");
        run_one(1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 6'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s_m1x5");
        run_one(1'b0, 32'h0001_0000, 32'h0001_0000, 6'd5, 32'h0000_0001, 32'h0000_0000, "u_2p32");
        run_one(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 6'd6, 32'hC000_0000, 32'h8000_0000, "s_maxxmin");

        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_signed = i[0];
            in_x      = $urandom;
            in_y      = $urandom;
            in_tag    = 6'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle("stream");

        out_ready = 1'b0;
        acc       = 0;
        for (int i = 0; i < ST + 3; i++) begin
            in_valid  = 1'b1;
            in_signed = 1'b1;
            in_x      = $urandom;
            in_y      = $urandom;
            in_tag    = 6'(32 + i);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc, ST);

        out_ready = 1'b1;
        in_tag    = 6'd50;
        @(negedge clk);
        ot = out_valid && out_ready;
        it = in_valid && in_ready;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out", ot, 1'b1);
        chk("bp_release_in", it, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_refull_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end

        flush  = 1'b1;
        in_tag = 6'd60;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        out_ready = 1'b1;
        repeat (ST + 2) @(posedge clk);
        #1;
        run_one(1'b0, 32'd3, 32'd7, 6'd7, 32'd0, 32'd21, "post_flush");

        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_signed = 1'b0;
            in_x      = 32'(i + 2);
            in_y      = 32'd3;
            in_tag    = 6'(40 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_imm_out_valid", out_valid, 1'b0);
        chk("rst_imm_busy", busy, 1'b0);
        chk("rst_imm_hi", out_hi, '0);
        chk("rst_imm_lo", out_lo, '0);
        chk("rst_imm_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        run_one(1'b1, 32'hFFFF_FFFE, 32'd3, 6'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "post_reset");

        for (int i = 0; i < 300; i++) begin
            a_valid  = ($urandom_range(0, 3) != 0);
            a_signed = 1'($urandom_range(0, 1));
            tmp = pick(16); a_x = tmp[15:0];
            tmp = pick(16); a_y = tmp[15:0];
            a_tag    = i[5:0];
            b_valid  = ($urandom_range(0, 3) != 0);
            b_signed = 1'($urandom_range(0, 1));
            b_x      = pick(64);
            b_y      = pick(64);
            b_tag    = i[5:0];
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("s16_drained", qa.size(), 0);
        chk("s64_drained", qb.size(), 0);
        chk("s16_busy_end", a_busy, 1'b0);
        chk("s64_busy_end", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, bench end not reached", $time);
        $fatal(1);
    end

endmodule
